// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: debounced key events, key code and a 4-digit hex entry register.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic        clock,
  input  logic        sys_rst_n,
  input  logic [3:0]  row_in,
  input  logic        clear,
  output logic [3:0]  col_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] value
);

  localparam int TP    = CLK_HZ / SCAN_HZ;
  localparam int DIV_W = (TP > 1) ? $clog2(TP) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t           r_state, w_nextState;
  logic [3:0]       r_rowMeta, r_rowSync;
  logic [DIV_W-1:0] r_divCnt;
  logic             w_tick;
  logic [3:0]       r_col, w_nextCol;
  logic [1:0]       r_colIdx, w_nextColIdx;
  logic [1:0]       r_rowIdx, w_nextRowIdx;
  logic [1:0]       w_lowRow;
  logic             w_rowLow;
  logic [CNT_W-1:0] r_cnt, w_nextCnt;
  logic             w_accept, w_releaseDone, w_heldTick, w_repeat;
  logic [3:0]       r_keyCode;
  logic             r_keyValid, r_keyHeld;
  logic [15:0]      r_value;

  // Rows are asynchronous to the clock, so everything downstream uses the synchronized copy.
  always_ff @(posedge clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rowMeta <= 4'b1111;
      r_rowSync <= 4'b1111;
    end else begin
      r_rowMeta <= row_in;
      r_rowSync <= r_rowMeta;
    end
  end

  always_ff @(posedge clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_divCnt <= '0;
    end else if (w_tick) begin
      r_divCnt <= '0;
    end else begin
      r_divCnt <= r_divCnt + DIV_W'(1);
    end
  end

  assign w_tick = (r_divCnt == DIV_W'(TP - 1));

  always_comb begin
    w_lowRow = 2'd3;
    if (!r_rowSync[0]) begin
      w_lowRow = 2'd0;
    end else if (!r_rowSync[1]) begin
      w_lowRow = 2'd1;
    end else if (!r_rowSync[2]) begin
      w_lowRow = 2'd2;
    end
  end

  assign w_rowLow = ~r_rowSync[r_rowIdx];

  always_ff @(posedge clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= SCAN;
      r_col    <= 4'b1110;
      r_colIdx <= 2'd0;
      r_rowIdx <= 2'd0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_nextState;
      r_col    <= w_nextCol;
      r_colIdx <= w_nextColIdx;
      r_rowIdx <= w_nextRowIdx;
      r_cnt    <= w_nextCnt;
    end
  end

  // The column stays frozen outside SCAN so the latched row keeps referring to the same key.
  always_comb begin
    w_nextState   = r_state;
    w_nextCol     = r_col;
    w_nextColIdx  = r_colIdx;
    w_nextRowIdx  = r_rowIdx;
    w_nextCnt     = r_cnt;
    w_accept      = 1'b0;
    w_releaseDone = 1'b0;
    w_heldTick    = 1'b0;
    case (r_state)
      SCAN: begin
        if (w_tick) begin
          if (r_rowSync != 4'b1111) begin
            w_nextRowIdx = w_lowRow;
            w_nextCnt    = CNT_W'(1);
            w_nextState  = DEBOUNCE;
          end else begin
            w_nextCol    = {r_col[2:0], r_col[3]};
            w_nextColIdx = r_colIdx + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (w_tick) begin
          if (!w_rowLow) begin
            w_nextState = SCAN;
          end else if (r_cnt == CNT_W'(DEBOUNCE_SCANS)) begin
            w_nextState = PRESSED;
            w_accept    = 1'b1;
          end else begin
            w_nextCnt = r_cnt + CNT_W'(1);
          end
        end
      end
      PRESSED: begin
        if (w_tick) begin
          if (!w_rowLow) begin
            w_nextCnt   = CNT_W'(1);
            w_nextState = RELEASE;
          end else begin
            w_heldTick = 1'b1;
          end
        end
      end
      RELEASE: begin
        if (w_tick) begin
          if (w_rowLow) begin
            w_nextState = PRESSED;
          end else if (r_cnt == CNT_W'(DEBOUNCE_SCANS)) begin
            w_nextState   = SCAN;
            w_releaseDone = 1'b1;
          end else begin
            w_nextCnt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: w_nextState = SCAN;
    endcase
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] r_repCnt, w_repCntInc;
  logic             r_repFirst;

  assign w_repCntInc = r_repCnt + REP_W'(1);
  assign w_repeat    = w_heldTick && (r_repFirst ? (w_repCntInc == REP_W'(REPEAT_DELAY))
                                                 : (w_repCntInc == REP_W'(REPEAT_RATE)));

  // First repeat waits the long delay, later ones use the shorter rate.
  always_ff @(posedge clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_repCnt   <= '0;
      r_repFirst <= 1'b0;
    end else if (w_accept) begin
      r_repCnt   <= '0;
      r_repFirst <= 1'b1;
    end else if (w_repeat) begin
      r_repCnt   <= '0;
      r_repFirst <= 1'b0;
    end else if (w_heldTick) begin
      r_repCnt <= w_repCntInc;
    end
  end
`else
  logic w_unusedRepeat;

  assign w_repeat       = 1'b0;
  assign w_unusedRepeat = ^{w_heldTick, 32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

  // Clear takes priority over a shift landing on the same edge.
  always_ff @(posedge clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_keyCode  <= 4'd0;
      r_keyValid <= 1'b0;
      r_keyHeld  <= 1'b0;
      r_value    <= 16'd0;
    end else begin
      r_keyValid <= w_accept | w_repeat;
      if (w_accept) begin
        r_keyCode <= {r_rowIdx, r_colIdx};
        r_keyHeld <= 1'b1;
      end else if (w_releaseDone) begin
        r_keyHeld <= 1'b0;
      end
      if (clear) begin
        r_value <= 16'd0;
      end else if (w_accept) begin
        r_value <= {r_value[11:0], r_rowIdx, r_colIdx};
      end else if (w_repeat) begin
        r_value <= {r_value[11:0], r_keyCode};
      end
    end
  end

  assign col_out   = r_col;
  assign key_code  = r_keyCode;
  assign key_valid = r_keyValid;
  assign key_held  = r_keyHeld;
  assign value     = r_value;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a simple key-matrix model and an event scoreboard.
// Expected auto-repeat behaviour follows KEYPAD_AUTOREPEAT_EN.
module tb_keypad_scanner;
  localparam int CLK_HZ         = 1000;
  localparam int SCAN_HZ        = 250;
  localparam int DEBOUNCE_SCANS = 2;
  localparam int REPEAT_DELAY   = 3;
  localparam int REPEAT_RATE    = 2;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] value;
  } expect_t;

  logic        clock      = 1'b0;
  logic        sys_rst_n  = 1'b0;
  logic        clear      = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] value;

  logic        keyDown    = 1'b0;
  logic [1:0]  keyRow     = 2'd0;
  logic [1:0]  keyCol     = 2'd0;
  logic [3:0]  glitchRows = 4'b1111;
  logic [15:0] expValue   = 16'd0;
  logic [3:0]  colSeq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0]  colBefore;
  expect_t     expQ [$];
  expect_t     popped;
  int          checks      = 0;
  int          errors      = 0;
  int          pulseCount  = 0;
  int          pulsesBefore;
  int          nExp;
  int          waitN;

  always #5 clock = ~clock;

  // A held key pulls its row low only while its column is driven.
  always_comb begin
    row_in = glitchRows;
    if (keyDown && !col_out[keyCol]) row_in[keyRow] = 1'b0;
  end

  keypad_scanner #(
    .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) dut (
    .clock(clock), .sys_rst_n(sys_rst_n), .row_in(row_in), .clear(clear),
    .col_out(col_out), .key_code(key_code), .key_valid(key_valid),
    .key_held(key_held), .value(value)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Every key_valid pulse consumes one scoreboard entry.
  always @(negedge clock) begin
    if (key_valid === 1'b1) begin
      pulseCount++;
      checkOutput("pulseExpected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        popped = expQ.pop_front();
        checkOutput("pulseCode", 32'(key_code), 32'(popped.code));
        checkOutput("pulseValue", 32'(value), 32'(popped.value));
      end
    end
  end

  task automatic waitValid(input string tag);
    int n = 0;
    while (key_valid !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    checkOutput(tag, 32'(key_valid), 32'd1);
  endtask

  task automatic applyStimulus(input logic [3:0] code);
    expValue = {expValue[11:0], code};
    expQ.push_back('{code, expValue});
    keyRow  = code[3:2];
    keyCol  = code[1:0];
    keyDown = 1'b1;
    waitValid("pressValid");
  endtask

  task automatic releaseKey();
    int n = 0;
    keyDown = 1'b0;
    while (key_held !== 1'b0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    checkOutput("releaseHeld", 32'(key_held), 32'd0);
  endtask

  task automatic checkResetOutputs(input string prefix);
    checkOutput({prefix, "Col"},   32'(col_out),   32'h0000_000E);
    checkOutput({prefix, "Code"},  32'(key_code),  32'd0);
    checkOutput({prefix, "Valid"}, 32'(key_valid), 32'd0);
    checkOutput({prefix, "Held"},  32'(key_held),  32'd0);
    checkOutput({prefix, "Value"}, 32'(value),     32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    checkResetOutputs("rst");
    sys_rst_n = 1'b1;

    // Idle scanning: one column step per tick.
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("idleCol%0d", i), 32'(col_out), 32'(colSeq[i % 4]));
      repeat (4) @(negedge clock);
    end
    checkOutput("idleNoValid", 32'(pulseCount), 32'd0);

    // Key r1,c1.
    applyStimulus(4'd5);
    checkOutput("k5Col", 32'(col_out), 32'h0000_000D);
    checkOutput("k5Held", 32'(key_held), 32'd1);
    @(negedge clock);
    checkOutput("k5OnePulse", 32'(key_valid), 32'd0);
    checkOutput("k5Code", 32'(key_code), 32'd5);
    checkOutput("k5Value", 32'(value), 32'h0000_0005);
    repeat (2) @(negedge clock);
    checkOutput("k5Frozen", 32'(col_out), 32'h0000_000D);
    keyDown = 1'b0;
    repeat (6) @(negedge clock);
    checkOutput("k5HeldAfterRelease", 32'(key_held), 32'd1);
    releaseKey();

    // One-tick glitch on row 0.
    pulsesBefore = pulseCount;
    glitchRows = 4'b1110;
    repeat (4) @(negedge clock);
    glitchRows = 4'b1111;
    repeat (16) @(negedge clock);
    checkOutput("glitchNoValid", 32'(pulseCount), 32'(pulsesBefore));
    checkOutput("glitchValue", 32'(value), 32'h0000_0005);
    colBefore = col_out;
    repeat (4) @(negedge clock);
    checkOutput("glitchScanning", 32'(col_out), 32'({colBefore[2:0], colBefore[3]}));

    // Hex entry sequence.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(4'(i));
      releaseKey();
    end
    checkOutput("seqValue", 32'(value), 32'h0000_2345);

    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    checkOutput("clearValue", 32'(value), 32'd0);
    expValue = 16'd0;

    // Clear held across the accepting edge of key 7.
    expQ.push_back('{4'd7, 16'h0000});
    keyRow  = 2'd1;
    keyCol  = 2'd3;
    keyDown = 1'b1;
    clear   = 1'b1;
    waitValid("clrCoValid");
    clear = 1'b0;
    checkOutput("clrCoValue", 32'(value), 32'd0);
    checkOutput("clrCoCode", 32'(key_code), 32'd7);
    releaseKey();

    // Hold key 0xA for ten ticks after acceptance.
`ifdef KEYPAD_AUTOREPEAT_EN
    nExp = 5;
`else
    nExp = 1;
`endif
    pulsesBefore = pulseCount;
    for (int i = 0; i < nExp; i++) begin
      expValue = {expValue[11:0], 4'hA};
      expQ.push_back('{4'hA, expValue});
    end
    keyRow  = 2'd2;
    keyCol  = 2'd2;
    keyDown = 1'b1;
    waitValid("holdFirstValid");
    repeat (37) @(negedge clock);
    releaseKey();
    checkOutput("holdPulses", 32'(pulseCount - pulsesBefore), 32'(nExp));
    checkOutput("holdValue", 32'(value), 32'(expValue));

    // Reset in the middle of debouncing key r1,c0.
    waitN = 0;
    while (col_out !== 4'b0111 && waitN < 20) begin
      @(negedge clock);
      waitN++;
    end
    checkOutput("rstPrevCol", 32'(col_out), 32'h0000_0007);
    keyRow  = 2'd1;
    keyCol  = 2'd0;
    keyDown = 1'b1;
    waitN = 0;
    while (col_out !== 4'b1110 && waitN < 8) begin
      @(negedge clock);
      waitN++;
    end
    checkOutput("rstKeyCol", 32'(col_out), 32'h0000_000E);
    repeat (6) @(negedge clock);
    pulsesBefore = pulseCount;
    sys_rst_n = 1'b0;
    @(negedge clock);
    checkResetOutputs("midRst");
    sys_rst_n = 1'b1;
    repeat (10) @(negedge clock);
    checkOutput("rstNoEarlyValid", 32'(pulseCount), 32'(pulsesBefore));
    expValue = 16'h0004;
    expQ.push_back('{4'd4, expValue});
    waitValid("rstRedebounce");
    releaseKey();

    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter SCAN_HZ, default 1000, column-step rate in Hz; tick period TP = CLK_HZ/SCAN_HZ cycles.
REQ-003 SHALL have parameter DEBOUNCE_SCANS, default 4, consecutive stable ticks required to accept a press or release.
REQ-004 SHALL have parameters REPEAT_DELAY, default 500, and REPEAT_RATE, default 100, both in ticks and used only under KEYPAD_AUTOREPEAT_EN.
REQ-005 clock  input  1  system clock; all state changes on its rising edge.
REQ-006 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 row_in  input  4  keypad rows, active-low (externally pulled up), asynchronous to clock.
REQ-008 clear  input  1  synchronous clear of value.
REQ-009 col_out  output  4  column drive, active-low, exactly one bit low at any time.
REQ-010 key_code  output  4  code of last accepted key, row*4+col.
REQ-011 key_valid  output  1  one-cycle pulse per accepted key event.
REQ-012 key_held  output  1  high while an accepted key is still down.
REQ-013 value  output  16  hex-entry shift register, 4 digits, directly usable as a 16-bit hex display source.

Function
REQ-014 row_in SHALL pass through a 2-flop synchronizer; all logic uses the synchronized copy rs.
REQ-015 A free-running divider SHALL assert a one-cycle tick every TP cycles, counting from 0 after reset.
REQ-016 FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
- SCAN: on tick, if rs != 4'b1111 latch col index c and lowest-index low row r, counter=1, go DEBOUNCE without advancing col_out; otherwise rotate col_out 1110->1101->1011->0111->1110.
- DEBOUNCE: col_out frozen; on tick, if row r still low, counter+1; at counter==DEBOUNCE_SCANS go PRESSED; if row r high, go SCAN.
- PRESSED: on entry, in the same cycle, key_valid=1 for one cycle, key_code=r*4+c, key_held=1, value<={value[11:0],key_code}; on tick with row r high, counter=1 and go RELEASE.
- RELEASE: on tick, row r high -> counter+1, at DEBOUNCE_SCANS key_held=0 and go SCAN; row r low -> back to PRESSED with no new key_valid.
REQ-017 Multiple rows low in one column: lowest row index wins; other columns ignored until return to SCAN.
REQ-018 Pressed-key latency: key_valid SHALL rise DEBOUNCE_SCANS ticks (+1 cycle) after the detecting tick.
REQ-019 clear SHALL set value to 0 next cycle; clear simultaneous with a key_valid shift SHALL win (value=0).
REQ-020 value SHALL shift left by 4 with the oldest digit discarded; no saturation.
REQ-021 key_code SHALL hold its value between events.

Reset
REQ-022 sys_rst_n low SHALL immediately force state=SCAN, col_out=4'b1110, key_code=0, key_valid=0, key_held=0, value=0, divider=0, counters=0, synchronizer=4'b1111.
REQ-023 Reset mid-debounce or mid-press SHALL discard the event; no key_valid after release of reset until a new full debounce.

Configuration
REQ-024 Macro KEYPAD_AUTOREPEAT_EN defined: in PRESSED with key held, key_valid re-pulses (with value shift) after REPEAT_DELAY ticks, then every REPEAT_RATE ticks until release.
REQ-025 Macro KEYPAD_AUTOREPEAT_EN undefined: exactly one key_valid per press; repeat counters absent from the netlist.

Verification (bench: CLK_HZ=1000, SCAN_HZ=250 so TP=4, DEBOUNCE_SCANS=2)
REQ-026 Reset, rows idle 4'b1111 for 40 cycles -> col_out cycles 1110,1101,1011,0111 every 4 cycles, key_valid never high.
REQ-027 Hold row1 low while col_out=1101 (key r1,c1) -> col_out freezes, one key_valid pulse, key_code=5, value=16'h0005, key_held=1 until 2 ticks after release.
REQ-028 Glitch: row0 low for 1 tick only -> return to SCAN, no key_valid, value unchanged.
REQ-029 Presses of codes 1,2,3,4,5 in sequence -> value=16'h2345 after fifth press; clear pulse -> value=16'h0000; clear coincident with a key_valid -> value=16'h0000.
REQ-030 sys_rst_n asserted during DEBOUNCE -> outputs at reset values next cycle, no key_valid on deassertion while key still held until re-debounced.
REQ-031 With KEYPAD_AUTOREPEAT_EN, REPEAT_DELAY=3, REPEAT_RATE=2, hold code 0xA for 10 ticks after accept -> pulses at accept, +3, +5, +7, +9 ticks; without macro -> single pulse.
